// File: rtl/dot_prod_pkg.sv
// Shared types and defaults for the dot-product sequencer and its watchdog.
package dot_prod_pkg;
    localparam int DEF_N       = 1000;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 27;
    localparam int DEF_RES_W   = 64;
    localparam int DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        HOLD
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BAD_IDX = 2'd2;
endpackage

// File: rtl/dot_prod_watchdog.sv
// Clearable run-cycle counter. o_expire flags the cycle whose increment reaches TIMEOUT,
// and the count itself doubles as the reported res_cycles.
module dot_prod_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;

    assign w_next   = r_count + 1'b1;
    assign o_count  = r_count;
    assign o_expire = i_en && (w_next >= CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end
endmodule

// File: rtl/dot_prod_sequencer.sv
// Host-side controller for one dot-product core: loads its operand arrays,
// launches a run, and returns result / error / cycle count over a valid-ready channel.
module dot_prod_sequencer
    import dot_prod_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [ADDR_W-1:0] cmd_i0,
    input  logic [RES_W-1:0]  cmd_acc0,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_a,
    input  logic [DATA_W-1:0] ld_b,
    output logic              load_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        res_err,
    output logic [31:0]       res_cycles,
    output logic              core_r_enable,
    output logic              core_control_arr,
    output logic [ADDR_W-1:0] core_init_i,
    output logic [RES_W-1:0]  core_init_acc,
    output logic              core_we_a,
    output logic              core_we_b,
    output logic [ADDR_W-1:0] core_addr_a,
    output logic [ADDR_W-1:0] core_addr_b,
    output logic [DATA_W-1:0] core_wdata_a,
    output logic [DATA_W-1:0] core_wdata_b,
    input  logic              core_w_enable,
    input  logic [RES_W-1:0]  core_result
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load_done;
    logic              r_r_enable;
    logic              r_ctrl_arr;
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [1:0]        r_res_err;
    logic [ADDR_W-1:0] r_i0;
    logic [RES_W-1:0]  r_acc0;

    logic w_cmd_fire;
    logic w_ld_fire;
    logic w_wd_clr;
    logic w_wd_expire;

    assign cmd_ready  = (r_state == IDLE);
    assign ld_ready   = (r_state == LOAD);
    assign w_cmd_fire = cmd_ready && cmd_valid;
    assign w_ld_fire  = ld_ready && ld_valid;

    // Array write ports are the only combinational path from host inputs to the core.
    assign core_we_a    = w_ld_fire;
    assign core_we_b    = w_ld_fire;
    assign core_addr_a  = w_ld_fire ? r_addr : '0;
    assign core_addr_b  = w_ld_fire ? r_addr : '0;
    assign core_wdata_a = w_ld_fire ? ld_a : '0;
    assign core_wdata_b = w_ld_fire ? ld_b : '0;

    assign core_r_enable    = r_r_enable;
    assign core_control_arr = r_ctrl_arr;
    assign core_init_i      = r_i0;
    assign core_init_acc    = r_acc0;
    assign load_done        = r_load_done;
    assign res_valid        = r_res_valid;
    assign res_data         = r_res_data;
    assign res_err          = r_res_err;

    // Any run command zeroes the count, so a rejected index reports 0 cycles.
    assign w_wd_clr = (r_state == ARM) || (w_cmd_fire && !cmd_load);

    dot_prod_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (32)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wd_clr),
        .i_en     (r_state == RUN),
        .o_count  (res_cycles),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_load_done <= 1'b0;
            r_r_enable  <= 1'b0;
            r_ctrl_arr  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= ERR_OK;
            r_i0        <= '0;
            r_acc0      <= '0;
        end else begin
            r_load_done <= 1'b0;
            r_r_enable  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        if (cmd_load) begin
                            r_state <= LOAD;
                            r_addr  <= '0;
                        end else begin
                            r_i0   <= cmd_i0;
                            r_acc0 <= cmd_acc0;
                            if (int'(cmd_i0) > N) begin
                                r_state     <= HOLD;
                                r_res_valid <= 1'b1;
                                r_res_data  <= '0;
                                r_res_err   <= ERR_BAD_IDX;
                            end else begin
                                r_state    <= ARM;
                                r_r_enable <= 1'b1;
                                r_ctrl_arr <= 1'b0;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (w_ld_fire) begin
                        if (r_addr == LAST_ADDR) begin
                            r_addr      <= '0;
                            r_state     <= IDLE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                ARM: r_state <= RUN;
                RUN: begin
                    // Completion beats a same-cycle timeout.
                    if (core_w_enable) begin
                        r_state     <= HOLD;
                        r_res_valid <= 1'b1;
                        r_res_data  <= core_result;
                        r_res_err   <= ERR_OK;
                        r_ctrl_arr  <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_state     <= HOLD;
                        r_res_valid <= 1'b1;
                        r_res_data  <= '0;
                        r_res_err   <= ERR_TIMEOUT;
                        r_ctrl_arr  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_prod_sequencer.sv
// Randomized bench: a stub core backed by its own memory, checked against a sum-of-products model.
module tb_dot_prod_sequencer;
    localparam int N      = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 27;
    localparam int RES_W  = 64;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_load;
    logic [ADDR_W-1:0] cmd_i0;
    logic [RES_W-1:0]  cmd_acc0;
    logic              ld_valid, ld_ready;
    logic [DATA_W-1:0] ld_a, ld_b;
    logic              load_done;
    logic              res_valid, res_ready;
    logic [RES_W-1:0]  res_data;
    logic [1:0]        res_err;
    logic [31:0]       res_cycles;
    logic              core_r_enable, core_control_arr;
    logic [ADDR_W-1:0] core_init_i;
    logic [RES_W-1:0]  core_init_acc;
    logic              core_we_a, core_we_b;
    logic [ADDR_W-1:0] core_addr_a, core_addr_b;
    logic [DATA_W-1:0] core_wdata_a, core_wdata_b;
    logic              core_w_enable;
    logic [RES_W-1:0]  core_result;

    always #5 clk = ~clk;

    dot_prod_sequencer #(
        .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_i0(cmd_i0), .cmd_acc0(cmd_acc0),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
        .load_done(load_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .res_cycles(res_cycles),
        .core_r_enable(core_r_enable), .core_control_arr(core_control_arr),
        .core_init_i(core_init_i), .core_init_acc(core_init_acc),
        .core_we_a(core_we_a), .core_we_b(core_we_b),
        .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b),
        .core_w_enable(core_w_enable), .core_result(core_result)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference model: operands as loaded by the host.
    longint ma [N];
    longint mb [N];

    function automatic longint model(input int i0, input longint acc);
        longint s = acc;
        for (int i = i0; i < N; i++) s += ma[i] * mb[i];
        return s;
    endfunction

    // Stub core: own memory, finishes stub_lat cycles after the start pulse unless hung.
    longint stub_a [N];
    longint stub_b [N];
    logic   stub_wen = 1'b0;
    longint stub_res = 0;
    int     stub_cnt = 0;
    bit     stub_hang = 1'b0;
    int     stub_lat = 3;
    int     wr_cnt = 0, exp_addr = 0, addr_err = 0;
    int     ren_cnt = 0, ld_done_cnt = 0, viol = 0;

    assign core_w_enable = stub_wen;
    assign core_result   = stub_res;

    function automatic longint stub_sum(input int i0, input longint acc);
        longint s = acc;
        for (int i = i0; i < N; i++) s += stub_a[i] * stub_b[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (core_we_a) begin
            stub_a[core_addr_a] = $signed(core_wdata_a);
            stub_b[core_addr_b] = $signed(core_wdata_b);
            if (int'(core_addr_a) != exp_addr || core_addr_b != core_addr_a || !core_we_b) addr_err++;
            exp_addr++;
            wr_cnt++;
        end
        if ((core_we_a || core_we_b) && !core_control_arr) viol++;
        if (load_done) ld_done_cnt++;
        if (core_r_enable) begin
            ren_cnt++;
            stub_wen <= 1'b0;
            stub_cnt <= stub_hang ? 0 : stub_lat;
            stub_res <= stub_sum(int'(core_init_i), core_init_acc);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_wen <= 1'b1;
        end
    end

    // All tasks start and end on a negedge.
    task automatic send_cmd(input bit load, input int i0, input longint acc0);
        int t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_load = load; cmd_i0 = ADDR_W'(i0); cmd_acc0 = acc0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input int mode, input int abort_at);
        int k = 0, t = 0, dn0;
        longint va, vb;
        logic signed [DATA_W-1:0] ra, rb;
        bit fire;
        wr_cnt = 0; exp_addr = 0; addr_err = 0; dn0 = ld_done_cnt;
        send_cmd(1'b1, 0, 0);
        while (k < N && t < 20000) begin
            t++;
            case (mode)
                0: begin va = 1; vb = 2; end
                1: begin va = k; vb = 1; end
                default: begin ra = DATA_W'($urandom); rb = DATA_W'($urandom); va = ra; vb = rb; end
            endcase
            ld_a = va[DATA_W-1:0]; ld_b = vb[DATA_W-1:0];
            if (k == abort_at) begin
                ld_valid = 1'b1; rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0; ld_valid = 1'b0;
                chk("rstld_cmd_ready", cmd_ready, 1);
                chk("rstld_ld_ready", ld_ready, 0);
                chk("rstld_ctrl_arr", core_control_arr, 1);
                chk("rstld_res_valid", res_valid, 0);
                return;
            end
            ld_valid = ($urandom_range(0, 3) != 0);
            fire = ld_valid && ld_ready;
            @(posedge clk);
            if (fire) begin ma[k] = va; mb[k] = vb; k++; end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("load_beats", k, N);
        chk("load_done_pulse", load_done, 1);
        @(negedge clk);
        chk("load_done_clear", load_done, 0);
        chk("wr_cnt", wr_cnt, N);
        chk("wr_addr_err", addr_err, 0);
        chk("load_done_count", ld_done_cnt - dn0, 1);
    endtask

    task automatic do_run(input int i0, input longint acc0, input bit hang, input int hold_cyc,
                          output longint data, output int err, output int cyc,
                          output int lat, output int ren_d);
        int t = 0, unstable = 0, ren0 = ren_cnt;
        longint d0;
        int e0, c0;
        stub_hang = hang;
        lat = $urandom_range(1, 10);
        stub_lat = lat;
        send_cmd(1'b0, i0, acc0);
        while (!res_valid && t < 200) begin @(negedge clk); t++; end
        chk("res_valid_wait", res_valid, 1);
        d0 = res_data; e0 = int'(res_err); c0 = int'(res_cycles);
        for (int k = 0; k < hold_cyc; k++) begin
            @(negedge clk);
            if (res_data !== d0 || int'(res_err) != e0 || int'(res_cycles) != c0 || !res_valid) unstable++;
        end
        if (hold_cyc > 0) chk("hold_stable", unstable, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("back_to_idle", cmd_ready, 1);
        data = d0; err = e0; cyc = c0; ren_d = ren_cnt - ren0;
    endtask

    initial begin
        longint d, acc;
        int e, c, lat, rd, i0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_i0 = '0; cmd_acc0 = '0;
        ld_valid = 1'b0; ld_a = '0; ld_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_cycles", res_cycles, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_r_enable", core_r_enable, 0);
        chk("rst_ctrl_arr", core_control_arr, 1);
        chk("rst_we", core_we_a, 0);
        rst = 1'b0;
        @(negedge clk);

        do_load(0, -1);
        do_run(0, 0, 1'b0, 0, d, e, c, lat, rd);
        chk("ones_data", d, 2000);
        chk("ones_err", e, 0);
        chk("ones_cycles", c, lat + 1);
        chk("ones_ren", rd, 1);

        do_load(1, -1);
        do_run(998, 5, 1'b0, 3, d, e, c, lat, rd);
        chk("ramp_data", d, 2002);
        chk("ramp_err", e, 0);
        chk("ramp_cycles", c, lat + 1);

        do_run(1000, -7, 1'b0, 0, d, e, c, lat, rd);
        chk("i0_n_data", d, -7);
        chk("i0_n_err", e, 0);
        do_run(1001, 123, 1'b0, 2, d, e, c, lat, rd);
        chk("badidx_data", d, 0);
        chk("badidx_err", e, 2);
        chk("badidx_cycles", c, 0);
        chk("badidx_ren", rd, 0);

        do_run(0, 0, 1'b1, 0, d, e, c, lat, rd);
        chk("tmo_data", d, 0);
        chk("tmo_err", e, 1);
        chk("tmo_cycles", c, TMO);
        do_run(500, 11, 1'b0, 0, d, e, c, lat, rd);
        chk("after_tmo_data", d, model(500, 11));
        chk("after_tmo_err", e, 0);

        do_load(2, -1);
        for (int r = 0; r < 4; r++) begin
            i0 = $urandom_range(0, N);
            acc = longint'($signed($urandom)) * 1000;
            do_run(i0, acc, 1'b0, 10, d, e, c, lat, rd);
            chk("rand_data", d, model(i0, acc));
            chk("rand_err", e, 0);
            chk("rand_cycles", c, lat + 1);
        end

        do_load(2, 500);

        stub_hang = 1'b1;
        send_cmd(1'b0, 0, 0);
        repeat (4) @(negedge clk);
        chk("run_ctrl_arr", core_control_arr, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstrun_cmd_ready", cmd_ready, 1);
        chk("rstrun_ctrl_arr", core_control_arr, 1);
        chk("rstrun_res_valid", res_valid, 0);
        chk("rstrun_cycles", res_cycles, 0);
        do_run(600, -3, 1'b0, 0, d, e, c, lat, rd);
        chk("recover_data", d, model(600, -3));

        chk("we_while_core_owns", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
